// File: rtl/ob_book_table_pkg.sv
// Shared types and default widths for the order-book side table.
package ob_book_table_pkg;

    localparam int unsigned OB_PRICE_W = 16;
    localparam int unsigned OB_QTY_W   = 16;
    localparam int unsigned OB_UID_W   = 32;

    typedef enum logic [1:0] {
        OP_INSERT = 2'd0,
        OP_CANCEL = 2'd1,
        OP_POP    = 2'd2,
        OP_REDUCE = 2'd3
    } ob_op_t;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_FULL     = 2'd1,
        ST_NOTFOUND = 2'd2,
        ST_DUP      = 2'd3
    } ob_status_t;

    typedef struct packed {
        logic [OB_UID_W-1:0]   uid;
        logic [OB_PRICE_W-1:0] price;
        logic [OB_QTY_W-1:0]   qty;
    } ob_entry_t;

    // Per-slot next-state selection driven by the table controller.
    typedef enum logic [2:0] {
        SL_HOLD = 3'd0,
        SL_LOAD = 3'd1,
        SL_SHUP = 3'd2,
        SL_SHDN = 3'd3,
        SL_DEC  = 3'd4
    } ob_slot_op_t;

endpackage

// File: rtl/ob_book_table_if.sv
// Command / response / head bundle between the book controller and one side table.
interface ob_book_table_if
    import ob_book_table_pkg::*;
#(
    parameter int unsigned N       = 16,
    parameter int unsigned PRICE_W = OB_PRICE_W,
    parameter int unsigned QTY_W   = OB_QTY_W,
    parameter int unsigned UID_W   = OB_UID_W
);
    localparam int unsigned CW = $clog2(N + 1);

    logic               cmd_vld;
    logic               cmd_rdy;
    ob_op_t             cmd_op;
    logic [UID_W-1:0]   cmd_uid;
    logic [PRICE_W-1:0] cmd_price;
    logic [QTY_W-1:0]   cmd_qty;

    logic               rsp_vld;
    ob_status_t         rsp_status;
    logic [UID_W-1:0]   rsp_uid;
    logic [PRICE_W-1:0] rsp_price;
    logic [QTY_W-1:0]   rsp_qty;

    logic               hd_vld;
    logic [UID_W-1:0]   hd_uid;
    logic [PRICE_W-1:0] hd_price;
    logic [QTY_W-1:0]   hd_qty;

    logic [CW-1:0]      cnt;
    logic               full;
    logic               empty;

    modport master (
        output cmd_vld, cmd_op, cmd_uid, cmd_price, cmd_qty,
        input  cmd_rdy,
        input  rsp_vld, rsp_status, rsp_uid, rsp_price, rsp_qty,
        input  hd_vld, hd_uid, hd_price, hd_qty,
        input  cnt, full, empty
    );

    modport slave (
        input  cmd_vld, cmd_op, cmd_uid, cmd_price, cmd_qty,
        output cmd_rdy,
        output rsp_vld, rsp_status, rsp_uid, rsp_price, rsp_qty,
        output hd_vld, hd_uid, hd_price, hd_qty,
        output cnt, full, empty
    );

endinterface

// File: rtl/ob_book_table_slot.sv
// One sorted-table storage slot: hold / load / shift-up / shift-down / decrement,
// plus local price-ordering and uid-match compares against the pending command.
module ob_book_table_slot
    import ob_book_table_pkg::*;
#(
    parameter int unsigned PRICE_W = OB_PRICE_W,
    parameter int unsigned QTY_W   = OB_QTY_W,
    parameter int unsigned UID_W   = OB_UID_W,
    parameter bit          IS_ASK  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  ob_slot_op_t        i_sel,
    // New entry; also the compare operand for ordering and uid match
    input  logic [UID_W-1:0]   i_new_uid,
    input  logic [PRICE_W-1:0] i_new_price,
    input  logic [QTY_W-1:0]   i_new_qty,
    input  logic               i_lo_vld,
    input  logic [UID_W-1:0]   i_lo_uid,
    input  logic [PRICE_W-1:0] i_lo_price,
    input  logic [QTY_W-1:0]   i_lo_qty,
    input  logic               i_hi_vld,
    input  logic [UID_W-1:0]   i_hi_uid,
    input  logic [PRICE_W-1:0] i_hi_price,
    input  logic [QTY_W-1:0]   i_hi_qty,
    input  logic [QTY_W-1:0]   i_dec_qty,
    output logic               o_vld,
    output logic [UID_W-1:0]   o_uid,
    output logic [PRICE_W-1:0] o_price,
    output logic [QTY_W-1:0]   o_qty,
    output logic               o_be_c,
    output logic               o_match_c
);

    logic               r_vld;
    logic [UID_W-1:0]   r_uid;
    logic [PRICE_W-1:0] r_price;
    logic [QTY_W-1:0]   r_qty;

    logic               w_vld_nxt;
    logic [UID_W-1:0]   w_uid_nxt;
    logic [PRICE_W-1:0] w_price_nxt;
    logic [QTY_W-1:0]   w_qty_nxt;

    always_comb begin : p_next
        w_vld_nxt   = r_vld;
        w_uid_nxt   = r_uid;
        w_price_nxt = r_price;
        w_qty_nxt   = r_qty;
        case (i_sel)
            SL_LOAD: begin
                w_vld_nxt   = 1'b1;
                w_uid_nxt   = i_new_uid;
                w_price_nxt = i_new_price;
                w_qty_nxt   = i_new_qty;
            end
            SL_SHUP: begin
                w_vld_nxt   = i_lo_vld;
                w_uid_nxt   = i_lo_uid;
                w_price_nxt = i_lo_price;
                w_qty_nxt   = i_lo_qty;
            end
            SL_SHDN: begin
                w_vld_nxt   = i_hi_vld;
                w_uid_nxt   = i_hi_uid;
                w_price_nxt = i_hi_price;
                w_qty_nxt   = i_hi_qty;
            end
            // Controller only selects this when i_dec_qty < r_qty
            SL_DEC:  w_qty_nxt = r_qty - i_dec_qty;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin : p_regs
        if (!rst) begin
            r_vld   <= 1'b0;
            r_uid   <= '0;
            r_price <= '0;
            r_qty   <= '0;
        end else begin
            r_vld   <= w_vld_nxt;
            r_uid   <= w_uid_nxt;
            r_price <= w_price_nxt;
            r_qty   <= w_qty_nxt;
        end
    end

    assign o_vld     = r_vld;
    assign o_uid     = r_uid;
    assign o_price   = r_price;
    assign o_qty     = r_qty;
    assign o_be_c    = r_vld & (IS_ASK ? (r_price <= i_new_price) : (r_price >= i_new_price));
    assign o_match_c = r_vld & (r_uid == i_new_uid);

endmodule

// File: rtl/ob_book_table.sv
// Price/time sorted order table for one book side; slot 0 is always the best order.
// Commands are captured on accept and applied to the slots on the following edge.
module ob_book_table
    import ob_book_table_pkg::*;
#(
    parameter int unsigned N       = 16,
    parameter int unsigned PRICE_W = OB_PRICE_W,
    parameter int unsigned QTY_W   = OB_QTY_W,
    parameter int unsigned UID_W   = OB_UID_W,
    parameter bit          IS_ASK  = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    ob_book_table_if.slave bus
);

    localparam int unsigned CW = $clog2(N + 1);

    logic               r_rdy;
    logic               r_pend;
    ob_op_t             r_op;
    logic [UID_W-1:0]   r_uid;
    logic [PRICE_W-1:0] r_price;
    logic [QTY_W-1:0]   r_qty;

    logic               r_rsp_vld;
    ob_status_t         r_rsp_st;
    logic [UID_W-1:0]   r_rsp_uid;
    logic [PRICE_W-1:0] r_rsp_price;
    logic [QTY_W-1:0]   r_rsp_qty;
    logic [CW-1:0]      r_cnt;
    logic               r_full;
    logic               r_empty;

    logic               w_acc;
    logic [N-1:0]       w_vld, w_be, w_match, w_from_hit;
    logic [UID_W-1:0]   w_uid   [N];
    logic [PRICE_W-1:0] w_price [N];
    logic [QTY_W-1:0]   w_qty   [N];
    logic [N-1:0]       w_lo_vld, w_hi_vld;
    logic [UID_W-1:0]   w_lo_uid   [N];
    logic [PRICE_W-1:0] w_lo_price [N];
    logic [QTY_W-1:0]   w_lo_qty   [N];
    logic [UID_W-1:0]   w_hi_uid   [N];
    logic [PRICE_W-1:0] w_hi_price [N];
    logic [QTY_W-1:0]   w_hi_qty   [N];
    ob_slot_op_t        w_sel [N];

    logic [CW-1:0]      w_pos;
    logic               w_seen;
    logic               w_hit;
    logic [UID_W-1:0]   w_m_uid;
    logic [PRICE_W-1:0] w_m_price;
    logic [QTY_W-1:0]   w_m_qty;

    ob_status_t         w_rsp_st;
    logic [UID_W-1:0]   w_rsp_uid;
    logic [PRICE_W-1:0] w_rsp_price;
    logic [QTY_W-1:0]   w_rsp_qty;
    logic [CW-1:0]      w_cnt_nxt;

    logic               w_contig_ok;
    logic               w_nodup_ok;

    assign w_acc = bus.cmd_vld & r_rdy;
    assign w_hit = |w_match;

    // Neighbour wiring; the chain ends feed an empty entry
    always_comb begin : p_nbr
        w_lo_vld[0]   = 1'b0;
        w_lo_uid[0]   = '0;
        w_lo_price[0] = '0;
        w_lo_qty[0]   = '0;
        for (int i = 1; i < int'(N); i++) begin
            w_lo_vld[i]   = w_vld[i-1];
            w_lo_uid[i]   = w_uid[i-1];
            w_lo_price[i] = w_price[i-1];
            w_lo_qty[i]   = w_qty[i-1];
        end
        w_hi_vld[N-1]   = 1'b0;
        w_hi_uid[N-1]   = '0;
        w_hi_price[N-1] = '0;
        w_hi_qty[N-1]   = '0;
        for (int i = 0; i < int'(N) - 1; i++) begin
            w_hi_vld[i]   = w_vld[i+1];
            w_hi_uid[i]   = w_uid[i+1];
            w_hi_price[i] = w_price[i+1];
            w_hi_qty[i]   = w_qty[i+1];
        end
    end

    for (genvar g = 0; g < int'(N); g++) begin : g_slot
        ob_book_table_slot #(
            .PRICE_W (PRICE_W),
            .QTY_W   (QTY_W),
            .UID_W   (UID_W),
            .IS_ASK  (IS_ASK)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .i_sel       (w_sel[g]),
            .i_new_uid   (r_uid),
            .i_new_price (r_price),
            .i_new_qty   (r_qty),
            .i_lo_vld    (w_lo_vld[g]),
            .i_lo_uid    (w_lo_uid[g]),
            .i_lo_price  (w_lo_price[g]),
            .i_lo_qty    (w_lo_qty[g]),
            .i_hi_vld    (w_hi_vld[g]),
            .i_hi_uid    (w_hi_uid[g]),
            .i_hi_price  (w_hi_price[g]),
            .i_hi_qty    (w_hi_qty[g]),
            .i_dec_qty   (r_qty),
            .o_vld       (w_vld[g]),
            .o_uid       (w_uid[g]),
            .o_price     (w_price[g]),
            .o_qty       (w_qty[g]),
            .o_be_c      (w_be[g]),
            .o_match_c   (w_match[g])
        );
    end

    // Insert position = count of better-or-equal entries; match prefix marks the cancel shift range
    always_comb begin : p_encode
        w_pos      = '0;
        w_seen     = 1'b0;
        w_from_hit = '0;
        w_m_uid    = '0;
        w_m_price  = '0;
        w_m_qty    = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (w_be[i]) w_pos = w_pos + CW'(1);
            if (w_match[i]) begin
                w_m_uid   = w_uid[i];
                w_m_price = w_price[i];
                w_m_qty   = w_qty[i];
            end
            w_seen        = w_seen | w_match[i];
            w_from_hit[i] = w_seen;
        end
    end

    always_comb begin : p_decode
        for (int i = 0; i < int'(N); i++) w_sel[i] = SL_HOLD;
        w_rsp_st    = ST_OK;
        w_rsp_uid   = '0;
        w_rsp_price = '0;
        w_rsp_qty   = '0;
        w_cnt_nxt   = r_cnt;
        if (r_pend) begin
            case (r_op)
                OP_INSERT: begin
                    if (w_hit) begin
                        w_rsp_st = ST_DUP;
                    end else if (r_cnt == CW'(N)) begin
                        w_rsp_st = ST_FULL;
                    end else begin
                        for (int i = 0; i < int'(N); i++) begin
                            if (CW'(i) == w_pos)     w_sel[i] = SL_LOAD;
                            else if (CW'(i) > w_pos) w_sel[i] = SL_SHUP;
                        end
                        w_rsp_uid   = r_uid;
                        w_rsp_price = r_price;
                        w_rsp_qty   = r_qty;
                        w_cnt_nxt   = r_cnt + CW'(1);
                    end
                end
                OP_CANCEL: begin
                    if (w_hit) begin
                        for (int i = 0; i < int'(N); i++)
                            if (w_from_hit[i]) w_sel[i] = SL_SHDN;
                        w_rsp_uid   = w_m_uid;
                        w_rsp_price = w_m_price;
                        w_rsp_qty   = w_m_qty;
                        w_cnt_nxt   = r_cnt - CW'(1);
                    end else begin
                        w_rsp_st = ST_NOTFOUND;
                    end
                end
                OP_POP: begin
                    if (w_vld[0]) begin
                        for (int i = 0; i < int'(N); i++) w_sel[i] = SL_SHDN;
                        w_rsp_uid   = w_uid[0];
                        w_rsp_price = w_price[0];
                        w_rsp_qty   = w_qty[0];
                        w_cnt_nxt   = r_cnt - CW'(1);
                    end else begin
                        w_rsp_st = ST_NOTFOUND;
                    end
                end
                OP_REDUCE: begin
                    if (!w_vld[0]) begin
                        w_rsp_st = ST_NOTFOUND;
                    end else if (r_qty < w_qty[0]) begin
                        w_sel[0]    = SL_DEC;
                        w_rsp_uid   = w_uid[0];
                        w_rsp_price = w_price[0];
                        w_rsp_qty   = r_qty;
                    end else begin
                        // Consumption saturates at the resting quantity and retires the head
                        for (int i = 0; i < int'(N); i++) w_sel[i] = SL_SHDN;
                        w_rsp_uid   = w_uid[0];
                        w_rsp_price = w_price[0];
                        w_rsp_qty   = w_qty[0];
                        w_cnt_nxt   = r_cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin : p_regs
        if (!rst) begin
            r_rdy       <= 1'b0;
            r_pend      <= 1'b0;
            r_op        <= OP_INSERT;
            r_uid       <= '0;
            r_price     <= '0;
            r_qty       <= '0;
            r_rsp_vld   <= 1'b0;
            r_rsp_st    <= ST_OK;
            r_rsp_uid   <= '0;
            r_rsp_price <= '0;
            r_rsp_qty   <= '0;
            r_cnt       <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
        end else begin
            r_rdy     <= 1'b1;
            r_pend    <= w_acc;
            r_rsp_vld <= r_pend;
            if (w_acc) begin
                r_op    <= bus.cmd_op;
                r_uid   <= bus.cmd_uid;
                r_price <= bus.cmd_price;
                r_qty   <= bus.cmd_qty;
            end
            if (r_pend) begin
                r_rsp_st    <= w_rsp_st;
                r_rsp_uid   <= w_rsp_uid;
                r_rsp_price <= w_rsp_price;
                r_rsp_qty   <= w_rsp_qty;
                r_cnt       <= w_cnt_nxt;
                r_full      <= (w_cnt_nxt == CW'(N));
                r_empty     <= (w_cnt_nxt == '0);
            end
        end
    end

    assign bus.cmd_rdy    = r_rdy;
    assign bus.rsp_vld    = r_rsp_vld;
    assign bus.rsp_status = r_rsp_st;
    assign bus.rsp_uid    = r_rsp_uid;
    assign bus.rsp_price  = r_rsp_price;
    assign bus.rsp_qty    = r_rsp_qty;
    assign bus.hd_vld     = w_vld[0];
    assign bus.hd_uid     = w_uid[0];
    assign bus.hd_price   = w_price[0];
    assign bus.hd_qty     = w_qty[0];
    assign bus.cnt        = r_cnt;
    assign bus.full       = r_full;
    assign bus.empty      = r_empty;

    // Table invariants: valid slots packed from slot 0, uids unique
    always_comb begin : p_inv
        w_contig_ok = 1'b1;
        w_nodup_ok  = 1'b1;
        for (int i = 1; i < int'(N); i++)
            if (w_vld[i] && !w_vld[i-1]) w_contig_ok = 1'b0;
        for (int i = 0; i < int'(N); i++)
            for (int j = i + 1; j < int'(N); j++)
                if (w_vld[i] && w_vld[j] && (w_uid[i] == w_uid[j])) w_nodup_ok = 1'b0;
    end

    a_table_ok: assert property (@(posedge clk) disable iff (!rst) (w_contig_ok && w_nodup_ok));

endmodule
